// File: rtl/bp_trace_serializer.sv
// Trace word FIFO that emits each stored word as R = in_width_p/out_width_p beats, LSB beat first.
// Optional macro TRACE_DROP_CNT_EN: never backpressure the encoder; count words discarded while full.
module bp_trace_serializer #(
    parameter int els_p       = 16,
    parameter int in_width_p  = 64,
    parameter int out_width_p = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [in_width_p-1:0]        trace_data_i,
    input  logic                         trace_v_i,
    output logic                         trace_ready_o,
    output logic [out_width_p-1:0]       beat_data_o,
    output logic                         beat_v_o,
    input  logic                         beat_ready_i,
    output logic                         beat_last_o,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic [31:0]                  drop_count_o
);

    localparam int R     = in_width_p / out_width_p;
    localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CNT_W = $clog2(els_p + 1);
    localparam int IDX_W = (R > 1) ? $clog2(R) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(els_p);

    // Pointers carry one extra wrap bit above the slot index.
    logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q,  count_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic                    init_q;

    logic [in_width_p-1:0]   mem_q [els_p];
    logic [in_width_p-1:0]   head_word;
    logic [out_width_p-1:0]  head_beats [R];

    logic full;
    logic empty;
    logic accept_ok;
    logic push;
    logic beat_fire;
    logic pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    // Readiness comes only from registered state, so a same-cycle pop never frees a slot.
    assign accept_ok = init_q & ~full;
    assign push      = trace_v_i & accept_ok;
    assign beat_fire = ~empty & beat_ready_i;
    assign pop       = beat_fire & (idx_q == LAST_IDX);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (beat_fire) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            init_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            init_q   <= 1'b1;
        end
    end

    // Storage is not reset; contents are only observed through valid pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= trace_data_i;
        end
    end

    assign head_word = mem_q[rd_ptr_q[PTR_W-1:0]];

    for (genvar gi = 0; gi < R; gi++) begin : g_beat
        assign head_beats[gi] = head_word[gi*out_width_p +: out_width_p];
    end

    assign beat_data_o = head_beats[idx_q];
    assign beat_v_o    = ~empty;
    assign beat_last_o = ~empty & (idx_q == LAST_IDX);
    assign count_o     = count_q;

`ifdef TRACE_DROP_CNT_EN
    logic        drop;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    assign drop          = trace_v_i & init_q & full;
    assign trace_ready_o = init_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count_o = drop_cnt_q;
`else
    assign trace_ready_o = accept_ok;
    assign drop_count_o  = 32'h0;
`endif

endmodule

// File: tb/tb_bp_trace_serializer.sv
// Directed self-checking bench for bp_trace_serializer with default parameters (16 x 64b, 32b beats).
module tb_bp_trace_serializer;

`ifdef TRACE_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk_i;
    logic        reset_n_i;
    logic [63:0] trace_data_i;
    logic        trace_v_i;
    logic        trace_ready_o;
    logic [31:0] beat_data_o;
    logic        beat_v_o;
    logic        beat_ready_i;
    logic        beat_last_o;
    logic [4:0]  count_o;
    logic [31:0] drop_count_o;

    int pass_cnt;
    int total_cnt;

    bp_trace_serializer #(
        .els_p      (16),
        .in_width_p (64),
        .out_width_p(32)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .trace_data_i (trace_data_i),
        .trace_v_i    (trace_v_i),
        .trace_ready_o(trace_ready_o),
        .beat_data_o  (beat_data_o),
        .beat_v_o     (beat_v_o),
        .beat_ready_i (beat_ready_i),
        .beat_last_o  (beat_last_o),
        .count_o      (count_o),
        .drop_count_o (drop_count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i    = 1'b0;
        trace_v_i    = 1'b0;
        trace_data_i = '0;
        beat_ready_i = 1'b0;
        tick();
        tick();
        total_cnt++; if (trace_ready_o !== 1'b0) $display("FAIL reset_ready got=%b exp=0", trace_ready_o); else pass_cnt++;
        total_cnt++; if (beat_v_o !== 1'b0) $display("FAIL reset_beat_v got=%b exp=0", beat_v_o); else pass_cnt++;
        total_cnt++; if (beat_last_o !== 1'b0) $display("FAIL reset_last got=%b exp=0", beat_last_o); else pass_cnt++;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count_o); else pass_cnt++;
        total_cnt++; if (drop_count_o !== 32'd0) $display("FAIL reset_drop got=%0d exp=0", drop_count_o); else pass_cnt++;
        reset_n_i = 1'b1;
        #1;
        total_cnt++; if (trace_ready_o !== 1'b0) $display("FAIL release_ready_early got=%b exp=0", trace_ready_o); else pass_cnt++;
        tick();
        total_cnt++; if (trace_ready_o !== 1'b1) $display("FAIL release_ready got=%b exp=1", trace_ready_o); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_two_beat();
        beat_ready_i = 1'b1;
        trace_data_i = 64'h1122_3344_5566_7788;
        trace_v_i    = 1'b1;
        tick();
        trace_v_i = 1'b0;
        total_cnt++; if (count_o !== 5'd1) $display("FAIL tb_count1 got=%0d exp=1", count_o); else pass_cnt++;
        total_cnt++; if (beat_v_o !== 1'b1) $display("FAIL tb_v0 got=%b exp=1", beat_v_o); else pass_cnt++;
        total_cnt++; if (beat_data_o !== 32'h5566_7788) $display("FAIL tb_beat0 got=%h exp=55667788", beat_data_o); else pass_cnt++;
        total_cnt++; if (beat_last_o !== 1'b0) $display("FAIL tb_last0 got=%b exp=0", beat_last_o); else pass_cnt++;
        tick();
        total_cnt++; if (beat_data_o !== 32'h1122_3344) $display("FAIL tb_beat1 got=%h exp=11223344", beat_data_o); else pass_cnt++;
        total_cnt++; if (beat_last_o !== 1'b1) $display("FAIL tb_last1 got=%b exp=1", beat_last_o); else pass_cnt++;
        total_cnt++; if (count_o !== 5'd1) $display("FAIL tb_count_mid got=%0d exp=1", count_o); else pass_cnt++;
        tick();
        total_cnt++; if (count_o !== 5'd0) $display("FAIL tb_count_end got=%0d exp=0", count_o); else pass_cnt++;
        total_cnt++; if (beat_v_o !== 1'b0) $display("FAIL tb_v_end got=%b exp=0", beat_v_o); else pass_cnt++;
        beat_ready_i = 1'b0;
        $display("test_two_beat done");
    endtask

    task automatic test_fill();
        logic [31:0] exp_beat;
        int          w;
        beat_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            trace_data_i = {32'hA000_0000 + i, 32'hB000_0000 + i};
            trace_v_i    = 1'b1;
            total_cnt++;
            if (trace_ready_o !== (DROP_EN || (i < 16)))
                $display("FAIL fill_ready[%0d] got=%b exp=%b", i, trace_ready_o, (DROP_EN || (i < 16)));
            else pass_cnt++;
            tick();
        end
        trace_v_i = 1'b0;
        total_cnt++; if (count_o !== 5'd16) $display("FAIL fill_count got=%0d exp=16", count_o); else pass_cnt++;
        total_cnt++; if (trace_ready_o !== DROP_EN) $display("FAIL full_ready got=%b exp=%b", trace_ready_o, DROP_EN); else pass_cnt++;
        total_cnt++; if (drop_count_o !== {31'd0, DROP_EN}) $display("FAIL fill_drop got=%0d exp=%0d", drop_count_o, DROP_EN); else pass_cnt++;
        beat_ready_i = 1'b1;
        for (int b = 0; b < 32; b++) begin
            w        = b / 2;
            exp_beat = (b % 2 == 1) ? 32'hA000_0000 + w : 32'hB000_0000 + w;
            total_cnt++;
            if ((beat_v_o !== 1'b1) || (beat_data_o !== exp_beat) || (beat_last_o !== (b % 2 == 1)))
                $display("FAIL drain_beat[%0d] got v=%b d=%h l=%b exp v=1 d=%h l=%b", b, beat_v_o, beat_data_o, beat_last_o, exp_beat, (b % 2 == 1));
            else pass_cnt++;
            tick();
        end
        total_cnt++; if (count_o !== 5'd0) $display("FAIL drain_count got=%0d exp=0", count_o); else pass_cnt++;
        beat_ready_i = 1'b0;
        $display("test_fill done");
    endtask

    task automatic test_push_pop_same();
        logic [63:0] words [4];
        logic [31:0] exp_beat;
        words[0] = 64'h0000_0010_0000_0011;
        words[1] = 64'h0000_0020_0000_0021;
        words[2] = 64'h0000_0030_0000_0031;
        words[3] = 64'h0000_0040_0000_0041;
        beat_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trace_data_i = words[i];
            trace_v_i    = 1'b1;
            tick();
        end
        trace_v_i = 1'b0;
        total_cnt++; if (count_o !== 5'd3) $display("FAIL pp_count_pre got=%0d exp=3", count_o); else pass_cnt++;
        beat_ready_i = 1'b1;
        tick();
        total_cnt++; if (beat_last_o !== 1'b1) $display("FAIL pp_last got=%b exp=1", beat_last_o); else pass_cnt++;
        trace_data_i = words[3];
        trace_v_i    = 1'b1;
        tick();
        trace_v_i = 1'b0;
        total_cnt++; if (count_o !== 5'd3) $display("FAIL pp_count_same got=%0d exp=3", count_o); else pass_cnt++;
        for (int b = 0; b < 6; b++) begin
            exp_beat = (b % 2 == 1) ? words[1 + b/2][63:32] : words[1 + b/2][31:0];
            total_cnt++;
            if ((beat_v_o !== 1'b1) || (beat_data_o !== exp_beat))
                $display("FAIL pp_beat[%0d] got v=%b d=%h exp v=1 d=%h", b, beat_v_o, beat_data_o, exp_beat);
            else pass_cnt++;
            tick();
        end
        total_cnt++; if (count_o !== 5'd0) $display("FAIL pp_count_end got=%0d exp=0", count_o); else pass_cnt++;
        beat_ready_i = 1'b0;
        $display("test_push_pop_same done");
    endtask

    task automatic test_reset_mid_word();
        beat_ready_i = 1'b0;
        trace_data_i = 64'hDEAD_BEEF_CAFE_F00D;
        trace_v_i    = 1'b1;
        tick();
        trace_v_i    = 1'b0;
        beat_ready_i = 1'b1;
        tick();
        beat_ready_i = 1'b0;
        total_cnt++; if (beat_data_o !== 32'hDEAD_BEEF) $display("FAIL mid_hi got=%h exp=deadbeef", beat_data_o); else pass_cnt++;
        reset_n_i = 1'b0;
        #2;
        total_cnt++; if (beat_v_o !== 1'b0) $display("FAIL mid_rst_v got=%b exp=0", beat_v_o); else pass_cnt++;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL mid_rst_count got=%0d exp=0", count_o); else pass_cnt++;
        total_cnt++; if (trace_ready_o !== 1'b0) $display("FAIL mid_rst_ready got=%b exp=0", trace_ready_o); else pass_cnt++;
        tick();
        reset_n_i = 1'b1;
        tick();
        trace_data_i = 64'h0BAD_0001_0BAD_0000;
        trace_v_i    = 1'b1;
        tick();
        trace_v_i = 1'b0;
        total_cnt++; if (beat_data_o !== 32'h0BAD_0000) $display("FAIL mid_new_lo got=%h exp=0bad0000", beat_data_o); else pass_cnt++;
        total_cnt++; if (beat_last_o !== 1'b0) $display("FAIL mid_new_last got=%b exp=0", beat_last_o); else pass_cnt++;
        beat_ready_i = 1'b1;
        tick();
        total_cnt++; if (beat_data_o !== 32'h0BAD_0001) $display("FAIL mid_new_hi got=%h exp=0bad0001", beat_data_o); else pass_cnt++;
        tick();
        total_cnt++; if (count_o !== 5'd0) $display("FAIL mid_new_count got=%0d exp=0", count_o); else pass_cnt++;
        beat_ready_i = 1'b0;
        $display("test_reset_mid_word done");
    endtask

    task automatic test_random_stall();
        logic [63:0] words [40];
        logic [31:0] lo_half;
        logic [31:0] prev_data;
        logic        prev_last;
        logic        prev_stall;
        logic        half;
        int          tx_idx;
        int          rx_idx;
        for (int k = 0; k < 40; k++) words[k] = {$urandom, $urandom};
        tx_idx     = 0;
        rx_idx     = 0;
        half       = 1'b0;
        prev_stall = 1'b0;
        lo_half    = '0;
        prev_data  = '0;
        prev_last  = 1'b0;
        for (int cyc = 0; cyc < 3000 && rx_idx < 40; cyc++) begin
            if (prev_stall) begin
                total_cnt++;
                if ((beat_v_o !== 1'b1) || (beat_data_o !== prev_data) || (beat_last_o !== prev_last))
                    $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b", beat_v_o, beat_data_o, beat_last_o, prev_data, prev_last);
                else pass_cnt++;
            end
            trace_v_i    = (tx_idx < 40) && trace_ready_o && (count_o < 5'd16) && ($urandom_range(0, 3) != 0);
            trace_data_i = (tx_idx < 40) ? words[tx_idx] : 64'h0;
            beat_ready_i = ($urandom_range(0, 1) == 1);
            if (trace_v_i) tx_idx++;
            prev_stall = beat_v_o && !beat_ready_i;
            prev_data  = beat_data_o;
            prev_last  = beat_last_o;
            if (beat_v_o && beat_ready_i) begin
                total_cnt++;
                if (beat_last_o !== half) $display("FAIL rx_last[%0d] got=%b exp=%b", rx_idx, beat_last_o, half);
                else pass_cnt++;
                if (!half) begin
                    lo_half = beat_data_o;
                end else begin
                    total_cnt++;
                    if ({beat_data_o, lo_half} !== words[rx_idx])
                        $display("FAIL rx_word[%0d] got=%h exp=%h", rx_idx, {beat_data_o, lo_half}, words[rx_idx]);
                    else pass_cnt++;
                    $display("rx word %0d = %h", rx_idx, {beat_data_o, lo_half});
                    rx_idx++;
                end
                half = ~half;
            end
            tick();
        end
        trace_v_i    = 1'b0;
        beat_ready_i = 1'b0;
        total_cnt++; if (rx_idx !== 40) $display("FAIL rx_total got=%0d exp=40", rx_idx); else pass_cnt++;
        total_cnt++; if (count_o !== 5'd0) $display("FAIL rx_count_end got=%0d exp=0", count_o); else pass_cnt++;
        $display("test_random_stall done");
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_two_beat();
        test_fill();
        test_push_pop_same();
        test_reset_mid_word();
        test_random_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
